if_id_pipe_reg: RTL
===================

// Module: if_id_pipe_reg
// PURPOSE
//  Parametrised IF->ID pipeline register with valid/ready handshake, optional 1-entry skid buffer,
//  synchronous flush (bubble insertion) and a saturating stall-cycle counter. Sits between fetch
//  (PC adder + instruction memory) and decode. Successor to the plain always-load IF/ID latch.
// PARAMETERS
//  PC_W       32            width of the PC+4 field
//  INSTR_W    32            width of the instruction field
//  NOP_INSTR  32'h0000_0000 instruction word driven on reset/flush (sll $0,$0,0)
//  SKID       1             1: 2-entry elastic (registered in_ready); 0: single-entry (comb in_ready)
//  CNT_W      16            width of stall_cnt
// PORTS
//  clock             in   1        rising-edge clock
//  reset_n           in   1        asynchronous, active-low reset
//  flush             in   1        sync kill of all held and incoming entries (branch/jump taken)
//  in_valid          in   1        fetch presents pc_add_out/im_out
//  in_ready          out  1        register can accept this cycle
//  pc_add_out        in   PC_W     PC+4 from fetch
//  im_out            in   INSTR_W  instruction from instruction memory
//  out_valid         out  1        IF_ID_* hold a live instruction
//  out_ready         in   1        decode consumes this cycle (0 = hazard stall)
//  IF_ID_pc_add_out  out  PC_W     registered PC+4
//  IF_ID_im_out      out  INSTR_W  registered instruction
//  stall_cnt         out  CNT_W    cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  - fire_in = in_valid & in_ready; fire_out = out_valid & out_ready. All outputs registered except
//    in_ready when SKID=0.
//  - Reset (reset_n=0, async): state EMPTY, out_valid 0, IF_ID_pc_add_out 0, IF_ID_im_out NOP_INSTR,
//    skid regs 0/NOP_INSTR, stall_cnt 0, in_ready 1 (SKID=1 reg resets to 1).
//  - States: EMPTY (no entry), FULL (main holds entry), SKID2 (main + skid hold entries; SKID=1 only).
//  - EMPTY: fire_in -> main<=in, FULL. Latency in->out = 1 cycle.
//  - FULL: fire_in&fire_out -> main<=in, stay FULL (full throughput, 1 instr/cycle);
//          fire_out only -> EMPTY; fire_in & !out_ready -> skid<=in, SKID2.
//  - SKID2: in_ready=0; out_ready -> main<=skid, FULL; else hold.
//  - in_ready: SKID=1 -> registered, = (next_state != SKID2); no comb path out_ready->in_ready.
//              SKID=0 -> out_ready | !out_valid (comb); SKID2 unreachable.
//  - Stall holds main/skid contents bit-exact; no entry ever dropped or duplicated.
//  - flush (highest priority, beats every transition): next state EMPTY, out_valid 0, main data <=
//    0/NOP_INSTR, skid cleared, input offered in the flush cycle discarded even if in_valid=1,
//    in_ready=1 next cycle. stall_cnt not cleared by flush.
//  - stall_cnt += 1 when out_valid & !out_ready & !flush; saturates at 2^CNT_W-1 (no wrap).
//  - Order preserved: main always older than skid.
// STRUCTURE
//  - Package if_id_pkg: state encoding (ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID2=2'd2), default NOP
//    constant.
//  - Data-width-agnostic handshake/state logic in sub-module pipe_skid_ctrl (outputs load_main,
//    load_skid, sel_skid, state); this module instantiates it and owns the datapath regs + counter.
//  - SKID selects logic via generate; skid regs absent when SKID=0.
// TESTING
//  - Reset mid-stream: assert reset_n=0 while FULL -> same cycle out_valid=0, IF_ID_im_out=0x00000000,
//    stall_cnt=0.
//  - Streaming: in_valid=1, out_ready=1, pc 4,8,12.. -> out 1 cycle later, one per cycle, no gaps.
//  - Back-pressure (SKID=1): out_ready=0 for 3 cycles after pc=4,8 -> in_ready falls after 2nd accept,
//    out holds pc=4; release -> 4 then 8 in order; stall_cnt=3.
//  - Flush in SKID2 with in_valid=1 pc=16 -> next cycle EMPTY, out_valid=0, pc 16 not delivered.
//  - SKID=0 back-pressure: out_ready=0 -> in_ready=0 same cycle; no loss across 5-cycle stall.
//  - Saturation (CNT_W=4): 20 stall cycles -> stall_cnt=15, holds 15.

Source files
------------

// File: rtl/if_id_pkg.sv
// if_id_pkg: shared state encoding and default NOP word for the IF/ID pipeline register.
package if_id_pkg;
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID2 = 2'd2
   } state_t;
   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/if_id_pipe_reg_ctrl.sv
// pipe_skid_ctrl: width-agnostic valid/ready handshake and occupancy state for a 1- or 2-entry stage.
module pipe_skid_ctrl
   import if_id_pkg::*;
#(
   parameter bit SKID = 1'b1
) (
   input  logic   clock,
   input  logic   reset_n,
   input  logic   flush,
   input  logic   in_valid,
   input  logic   out_ready,
   output logic   in_ready,
   output logic   load_main,
   output logic   load_skid,
   output logic   sel_skid,
   output state_t state
);
   state_t nxt;
   logic   fire_in;
   assign fire_in  = in_valid & in_ready;
   assign sel_skid = state == ST_SKID2;
   always_comb begin
      nxt       = state;
      load_main = 1'b0;
      load_skid = 1'b0;
      if (flush) nxt = ST_EMPTY;
      else
         unique case (state)
            ST_EMPTY: begin
               load_main = fire_in;
               nxt       = fire_in ? ST_FULL : ST_EMPTY;
            end
            ST_FULL:
               if (out_ready) begin
                  load_main = fire_in;
                  nxt       = fire_in ? ST_FULL : ST_EMPTY;
               end else if (fire_in && SKID) begin
                  load_skid = 1'b1;
                  nxt       = ST_SKID2;
               end
            ST_SKID2: begin
               load_main = out_ready;
               nxt       = out_ready ? ST_FULL : ST_SKID2;
            end
            default: nxt = ST_EMPTY;
         endcase
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= ST_EMPTY;
      else state <= nxt;
   generate
      if (SKID) begin : g_reg_ready
         // Registered ready breaks the out_ready -> in_ready combinational path.
         logic rdy;
         always_ff @(posedge clock or negedge reset_n)
            if (!reset_n) rdy <= 1'b1;
            else rdy <= nxt != ST_SKID2;
         assign in_ready = rdy;
      end else begin : g_comb_ready
         assign in_ready = out_ready | (state == ST_EMPTY);
      end
   endgenerate
endmodule

// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF->ID pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall-cycle counter.
module if_id_pipe_reg
   import if_id_pkg::*;
#(
   parameter int                   PC_W      = 32,
   parameter int                   INSTR_W   = 32,
   parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(NOP_DEFAULT),
   parameter bit                   SKID      = 1'b1,
   parameter int                   CNT_W     = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    pc_add_out,
   input  logic [INSTR_W-1:0] im_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    IF_ID_pc_add_out,
   output logic [INSTR_W-1:0] IF_ID_im_out,
   output logic [CNT_W-1:0]   stall_cnt
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   state_t               state;
   logic                 load_main, load_skid, sel_skid;
   logic [PC_W-1:0]      skid_pc;
   logic [INSTR_W-1:0]   skid_im;
   pipe_skid_ctrl #(.SKID(SKID)) u_ctrl (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .load_main (load_main),
      .load_skid (load_skid),
      .sel_skid  (sel_skid),
      .state     (state)
   );
   assign out_valid = state != ST_EMPTY;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         IF_ID_pc_add_out <= '0;
         IF_ID_im_out     <= NOP_INSTR;
      end else if (flush) begin
         IF_ID_pc_add_out <= '0;
         IF_ID_im_out     <= NOP_INSTR;
      end else if (load_main) begin
         IF_ID_pc_add_out <= sel_skid ? skid_pc : pc_add_out;
         IF_ID_im_out     <= sel_skid ? skid_im : im_out;
      end
   generate
      if (SKID) begin : g_skid
         always_ff @(posedge clock or negedge reset_n)
            if (!reset_n) begin
               skid_pc <= '0;
               skid_im <= NOP_INSTR;
            end else if (flush) begin
               skid_pc <= '0;
               skid_im <= NOP_INSTR;
            end else if (load_skid) begin
               skid_pc <= pc_add_out;
               skid_im <= im_out;
            end
      end else begin : g_noskid
         logic ctrl_unused;
         assign ctrl_unused = load_skid;
         assign skid_pc     = '0;
         assign skid_im     = NOP_INSTR;
      end
   endgenerate
   // Counts hazard-stall cycles; survives flush, only reset clears it.
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) stall_cnt <= '0;
      else if (out_valid && !out_ready && !flush && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
endmodule
